// File: rtl/pwr_event_ctrl.sv
// Power event controller: debounces the front-panel button, synchronizes BMC
// and SLP_S3# controls, and sequences PSU on/off with fault latching.
module pwr_event_ctrl #(
  parameter int unsigned T_SETTLE  = 100,
  parameter int unsigned T_PSOK_TO = 1000,
  parameter int unsigned T_OFF_MIN = 2000,
  parameter int unsigned T_FORCE   = 4000,
  parameter int unsigned T_DEB     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt1ms_done,
  input  logic       pwrbtn_n,
  input  logic       bmc_onctl_n,
  input  logic       slps3_n,
  input  logic       ps_pwrok,
  input  logic       thermtrip_n,
  input  logic       ac_restore_on,
  output logic       pson_from_pwr_event,
  output logic [3:0] power_evt_state,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int unsigned CNT_W = 13;
  localparam int unsigned DEB_W = (T_DEB > 1) ? $clog2(T_DEB) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] SETTLE_MS   = CNT_W'(T_SETTLE);
  localparam logic [CNT_W-1:0] PSOK_TO_MS  = CNT_W'(T_PSOK_TO);
  localparam logic [CNT_W-1:0] OFF_MIN_MS  = CNT_W'(T_OFF_MIN);
  localparam logic [CNT_W-1:0] FORCE_MS    = CNT_W'(T_FORCE);
  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(T_DEB - 1);

  typedef enum logic [3:0] {
    ST_INIT     = 4'h0,
    ST_OFF      = 4'h1,
    ST_PSON     = 4'h2,
    ST_ON       = 4'h3,
    ST_SHUTDOWN = 4'h4,
    ST_FAULT    = 4'h5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ms_q, ms_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             btn_deb_q, btn_deb_d;
  logic             press_q, press_d;
  logic [2:0]       bmc_q;
  logic [2:0]       slp_q;
  logic             pson_q, pson_d;
  logic             fault_q, fault_d;
  logic [1:0]       code_q, code_d;

  logic bmc_fall, bmc_rise, slp_fall;

  // Edge detect on the synchronized copies (bit 1 = synced, bit 2 = previous)
  assign bmc_fall = bmc_q[2] & ~bmc_q[1];
  assign bmc_rise = ~bmc_q[2] & bmc_q[1];
  assign slp_fall = slp_q[2] & ~slp_q[1];

  // Button debounce: flip the level after T_DEB consecutive differing samples
  always_comb begin
    btn_deb_d = btn_deb_q;
    deb_cnt_d = deb_cnt_q;
    if (cnt1ms_done) begin
      if (pwrbtn_n == btn_deb_q) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        btn_deb_d = pwrbtn_n;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    press_d = btn_deb_q & ~btn_deb_d;
  end

  // Hold counter: ms of debounced-low button, saturating
  always_comb begin
    hold_d = hold_q;
    if (btn_deb_q) begin
      hold_d = '0;
    end else if (cnt1ms_done && (hold_q != CNT_MAX)) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Next-state, fault latch and registered-output decode
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    unique case (state_q)
      ST_INIT: begin
        if (ms_q >= SETTLE_MS) state_d = ac_restore_on ? ST_PSON : ST_OFF;
      end
      ST_OFF: begin
        if (press_q || bmc_fall) state_d = ST_PSON;
      end
      ST_PSON: begin
        if (ps_pwrok) begin
          state_d = ST_ON;
        end else if (ms_q >= PSOK_TO_MS) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = 2'd1;
        end
      end
      ST_ON: begin
        if (!thermtrip_n) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = 2'd3;
        end else if (!ps_pwrok) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = 2'd2;
        end else if (slp_fall || bmc_rise || (hold_q >= FORCE_MS)) begin
          state_d = ST_SHUTDOWN;
        end
      end
      ST_SHUTDOWN: begin
        if ((ms_q >= OFF_MIN_MS) && !ps_pwrok) state_d = ST_OFF;
      end
      ST_FAULT: begin
        if (press_q && !ps_pwrok) begin
          state_d = ST_OFF;
          fault_d = 1'b0;
          code_d  = 2'd0;
        end
      end
      default: state_d = ST_INIT;
    endcase
    pson_d = (state_d == ST_PSON) || (state_d == ST_ON);
  end

  // ms counter: cleared on every state change, saturating otherwise
  always_comb begin
    ms_d = ms_q;
    if (state_d != state_q) begin
      ms_d = '0;
    end else if (cnt1ms_done && (ms_q != CNT_MAX)) begin
      ms_d = ms_q + 1'b1;
    end
  end

  // All state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      ms_q      <= '0;
      hold_q    <= '0;
      deb_cnt_q <= '0;
      btn_deb_q <= 1'b1;
      press_q   <= 1'b0;
      bmc_q     <= 3'b111;
      slp_q     <= 3'b111;
      pson_q    <= 1'b0;
      fault_q   <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      ms_q      <= ms_d;
      hold_q    <= hold_d;
      deb_cnt_q <= deb_cnt_d;
      btn_deb_q <= btn_deb_d;
      press_q   <= press_d;
      bmc_q     <= {bmc_q[1:0], bmc_onctl_n};
      slp_q     <= {slp_q[1:0], slps3_n};
      pson_q    <= pson_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
    end
  end

  assign pson_from_pwr_event = pson_q;
  assign power_evt_state     = state_q;
  assign fault               = fault_q;
  assign fault_code          = code_q;

endmodule

// File: tb/tb_pwr_event_ctrl.sv
// Directed scoreboard bench for pwr_event_ctrl with default timing parameters.
module tb_pwr_event_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cnt1ms_done = 1'b0;
  logic       pwrbtn_n = 1'b1;
  logic       bmc_onctl_n = 1'b1;
  logic       slps3_n = 1'b1;
  logic       ps_pwrok = 1'b0;
  logic       thermtrip_n = 1'b1;
  logic       ac_restore_on = 1'b0;
  logic       pson_from_pwr_event;
  logic [3:0] power_evt_state;
  logic       fault;
  logic [1:0] fault_code;

  localparam logic [3:0] S_INIT = 4'h0;
  localparam logic [3:0] S_OFF  = 4'h1;
  localparam logic [3:0] S_PSON = 4'h2;
  localparam logic [3:0] S_ON   = 4'h3;
  localparam logic [3:0] S_SHDN = 4'h4;
  localparam logic [3:0] S_FLT  = 4'h5;

  typedef struct {
    logic [3:0] st;
    logic       pson;
    logic       flt;
    logic [1:0] code;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_err = 0;

  pwr_event_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .cnt1ms_done         (cnt1ms_done),
    .pwrbtn_n            (pwrbtn_n),
    .bmc_onctl_n         (bmc_onctl_n),
    .slps3_n             (slps3_n),
    .ps_pwrok            (ps_pwrok),
    .thermtrip_n         (thermtrip_n),
    .ac_restore_on       (ac_restore_on),
    .pson_from_pwr_event (pson_from_pwr_event),
    .power_evt_state     (power_evt_state),
    .fault               (fault),
    .fault_code          (fault_code)
  );

  always #5 clk = ~clk;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 1 ms tick pulse followed by idle clocks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) cnt1ms_done = 1'b1;
      @(negedge clk) cnt1ms_done = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] st, input logic p,
                            input logic f, input logic [1:0] c);
    exp_t e;
    e.st = st; e.pson = p; e.flt = f; e.code = c;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    n_checks++;
    assert (sb_q.size() > 0) else begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0d expected>0", sb_q.size());
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      assert (power_evt_state === e.st) else begin
        n_err++;
        $error("FAIL %s.state observed=%0h expected=%0h", t, power_evt_state, e.st);
      end
      n_checks++;
      assert (pson_from_pwr_event === e.pson) else begin
        n_err++;
        $error("FAIL %s.pson observed=%0b expected=%0b", t, pson_from_pwr_event, e.pson);
      end
      n_checks++;
      assert (fault === e.flt) else begin
        n_err++;
        $error("FAIL %s.fault observed=%0b expected=%0b", t, fault, e.flt);
      end
      n_checks++;
      assert (fault_code === e.code) else begin
        n_err++;
        $error("FAIL %s.code observed=%0d expected=%0d", t, fault_code, e.code);
      end
    end
  endtask

  initial begin
    // Reset state
    clks(2);
    expect_out("reset", S_INIT, 1'b0, 1'b0, 2'd0); check_out();
    rst = 1'b0;

    // Settle to OFF, then debounced press to PSON and PSU ok to ON
    tick(99);  expect_out("init_99ms", S_INIT, 1'b0, 1'b0, 2'd0); check_out();
    tick(1);   expect_out("off_100ms", S_OFF, 1'b0, 1'b0, 2'd0); check_out();
    pwrbtn_n = 1'b0;
    tick(15);  expect_out("press_15ms", S_OFF, 1'b0, 1'b0, 2'd0); check_out();
    tick(1);   expect_out("press_16ms", S_PSON, 1'b1, 1'b0, 2'd0); check_out();
    tick(4);   expect_out("press_20ms", S_PSON, 1'b1, 1'b0, 2'd0); check_out();
    ps_pwrok = 1'b1;
    clks(1);   expect_out("pwrok_on", S_ON, 1'b1, 1'b0, 2'd0); check_out();

    // Thermtrip and PSOK loss together: thermtrip wins
    thermtrip_n = 1'b0; ps_pwrok = 1'b0;
    clks(1);   expect_out("thermtrip", S_FLT, 1'b0, 1'b1, 2'd3); check_out();
    thermtrip_n = 1'b1;
    pwrbtn_n = 1'b1; tick(16);
    ps_pwrok = 1'b1; pwrbtn_n = 1'b0; tick(16);
    expect_out("fault_press_pwrok", S_FLT, 1'b0, 1'b1, 2'd3); check_out();
    pwrbtn_n = 1'b1; tick(16);
    ps_pwrok = 1'b0; pwrbtn_n = 1'b0; tick(16);
    expect_out("fault_exit", S_OFF, 1'b0, 1'b0, 2'd0); check_out();
    pwrbtn_n = 1'b1; tick(16);

    // Glitch rejected; BMC fall coincident with press gives one entry to PSON
    pwrbtn_n = 1'b0; tick(10); pwrbtn_n = 1'b1; tick(10);
    expect_out("glitch", S_OFF, 1'b0, 1'b0, 2'd0); check_out();
    pwrbtn_n = 1'b0; tick(15);
    @(negedge clk) bmc_onctl_n = 1'b0;
    @(negedge clk) cnt1ms_done = 1'b1;
    @(negedge clk) cnt1ms_done = 1'b0;
    expect_out("dual_pre", S_OFF, 1'b0, 1'b0, 2'd0); check_out();
    clks(1);   expect_out("dual_pson", S_PSON, 1'b1, 1'b0, 2'd0); check_out();
    clks(4);   expect_out("dual_stay", S_PSON, 1'b1, 1'b0, 2'd0); check_out();
    ps_pwrok = 1'b1;
    clks(1);   expect_out("dual_on", S_ON, 1'b1, 1'b0, 2'd0); check_out();

    // Forced off by 4000 ms hold, SHUTDOWN minimum dwell, held button no re-trigger
    tick(3999); expect_out("hold_3999", S_ON, 1'b1, 1'b0, 2'd0); check_out();
    tick(1);    expect_out("hold_4000", S_SHDN, 1'b0, 1'b0, 2'd0); check_out();
    bmc_onctl_n = 1'b1;
    tick(500); ps_pwrok = 1'b0;
    tick(1499); expect_out("shdn_1999", S_SHDN, 1'b0, 1'b0, 2'd0); check_out();
    tick(1);    expect_out("shdn_2000", S_OFF, 1'b0, 1'b0, 2'd0); check_out();
    tick(20);   expect_out("held_off", S_OFF, 1'b0, 1'b0, 2'd0); check_out();

    // BMC fall alone turns on; BMC rise in ON shuts down; dwell needs PSOK low
    pwrbtn_n = 1'b1; tick(16);
    bmc_onctl_n = 1'b0;
    clks(2);   expect_out("bmc_sync", S_OFF, 1'b0, 1'b0, 2'd0); check_out();
    clks(1);   expect_out("bmc_fall", S_PSON, 1'b1, 1'b0, 2'd0); check_out();
    ps_pwrok = 1'b1; clks(1);
    bmc_onctl_n = 1'b1;
    clks(3);   expect_out("bmc_rise", S_SHDN, 1'b0, 1'b0, 2'd0); check_out();
    tick(2000); expect_out("shdn_pwrok_hi", S_SHDN, 1'b0, 1'b0, 2'd0); check_out();
    ps_pwrok = 1'b0;
    clks(1);   expect_out("shdn_pwrok_lo", S_OFF, 1'b0, 1'b0, 2'd0); check_out();

    // SLP_S3# fall in ON shuts down
    pwrbtn_n = 1'b0; tick(16);
    ps_pwrok = 1'b1; clks(1);
    expect_out("on_again", S_ON, 1'b1, 1'b0, 2'd0); check_out();
    slps3_n = 1'b0;
    clks(3);   expect_out("slp_fall", S_SHDN, 1'b0, 1'b0, 2'd0); check_out();
    slps3_n = 1'b1; ps_pwrok = 1'b0;
    tick(2000); expect_out("slp_off", S_OFF, 1'b0, 1'b0, 2'd0); check_out();

    // PSOK lost in ON
    pwrbtn_n = 1'b1; tick(16);
    pwrbtn_n = 1'b0; tick(16);
    ps_pwrok = 1'b1; clks(1);
    ps_pwrok = 1'b0;
    clks(1);   expect_out("psok_lost", S_FLT, 1'b0, 1'b1, 2'd2); check_out();
    pwrbtn_n = 1'b1; tick(16);
    pwrbtn_n = 1'b0; tick(16);
    expect_out("psok_lost_exit", S_OFF, 1'b0, 1'b0, 2'd0); check_out();

    // Reset pulse in ON
    pwrbtn_n = 1'b1; tick(16);
    pwrbtn_n = 1'b0; tick(16);
    ps_pwrok = 1'b1; clks(1);
    rst = 1'b1;
    clks(1);   expect_out("rst_in_on", S_INIT, 1'b0, 1'b0, 2'd0); check_out();
    pwrbtn_n = 1'b1; ps_pwrok = 1'b0; ac_restore_on = 1'b1;
    clks(2); rst = 1'b0;

    // AC restore on, PSOK timeout, fault cleared by press
    tick(99);  expect_out("ac_99ms", S_INIT, 1'b0, 1'b0, 2'd0); check_out();
    tick(1);   expect_out("ac_pson", S_PSON, 1'b1, 1'b0, 2'd0); check_out();
    ac_restore_on = 1'b0;
    tick(999); expect_out("psok_999", S_PSON, 1'b1, 1'b0, 2'd0); check_out();
    tick(1);   expect_out("psok_to", S_FLT, 1'b0, 1'b1, 2'd1); check_out();
    pwrbtn_n = 1'b0; tick(16);
    expect_out("psok_to_exit", S_OFF, 1'b0, 1'b0, 2'd0); check_out();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
